// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_if
// Brief    : Control/status bundle between the multicycle controller and datapath
// Revision : 1.0
// ============================================================================
interface multicycle_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en;
   logic       i_or_d;
   logic       ir_write;
   logic       ALU_src_a;
   logic [1:0] ALU_src_b;
   logic [2:0] ALU_control;
   logic [1:0] pc_src;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       mem_write;
   logic       illegal_instr;
   logic       bus_error;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, mem_ready,
      output pc_en, i_or_d, ir_write, ALU_src_a, ALU_src_b, ALU_control, pc_src,
             reg_dst, mem_to_reg, reg_write, mem_write, illegal_instr, bus_error, state
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pc_en, i_or_d, ir_write, ALU_src_a, ALU_src_b, ALU_control, pc_src,
             reg_dst, mem_to_reg, reg_write, mem_write, illegal_instr, bus_error, state
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : MIPS-style multicycle control FSM with memory-wait timeout trap
// Revision : 1.0
// ============================================================================
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 255
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   multicycle_controller_if.master bus
);
   localparam logic [3:0] c_ST_FETCH    = 4'd0;
   localparam logic [3:0] c_ST_DECODE   = 4'd1;
   localparam logic [3:0] c_ST_MEMADR   = 4'd2;
   localparam logic [3:0] c_ST_MEMREAD  = 4'd3;
   localparam logic [3:0] c_ST_MEMWB    = 4'd4;
   localparam logic [3:0] c_ST_MEMWRITE = 4'd5;
   localparam logic [3:0] c_ST_EXECUTE  = 4'd6;
   localparam logic [3:0] c_ST_ALUWB    = 4'd7;
   localparam logic [3:0] c_ST_BRANCH   = 4'd8;
   localparam logic [3:0] c_ST_ADDIEX   = 4'd9;
   localparam logic [3:0] c_ST_ADDIWB   = 4'd10;
   localparam logic [3:0] c_ST_JUMP     = 4'd11;
   localparam logic [3:0] c_ST_TRAP     = 4'd12;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_J     = 6'b000010;

   localparam logic [5:0] c_FN_ADD = 6'b100000;
   localparam logic [5:0] c_FN_SUB = 6'b100010;
   localparam logic [5:0] c_FN_AND = 6'b100100;
   localparam logic [5:0] c_FN_OR  = 6'b100101;
   localparam logic [5:0] c_FN_SLT = 6'b101010;

   localparam logic [2:0] c_ALU_ADD = 3'b010;
   localparam logic [2:0] c_ALU_SUB = 3'b110;
   localparam logic [2:0] c_ALU_AND = 3'b000;
   localparam logic [2:0] c_ALU_OR  = 3'b001;
   localparam logic [2:0] c_ALU_SLT = 3'b111;

   localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [7:0] r_wait_cnt;
   logic       r_cause_bus;
   logic       w_timeout;
   logic       w_funct_ok;

   assign w_timeout = (r_wait_cnt == c_TIMEOUT) && !bus.mem_ready;
   assign bus.state = r_state;

   always_comb begin
      case (bus.funct)
         c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: w_funct_ok = 1'b1;
         default:                                        w_funct_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Only the three wait states ever stay put, so any state change is an entry that clears the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt  <= 8'd0;
         r_cause_bus <= 1'b0;
      end else begin
         r_wait_cnt <= (w_next == r_state) ? r_wait_cnt + 8'd1 : 8'd0;
         if (w_next == c_ST_TRAP) begin
            r_cause_bus <= (r_state != c_ST_DECODE);
         end
      end
   end

   always_comb begin
      w_next = c_ST_FETCH;
      case (r_state)
         c_ST_FETCH: begin
            if (bus.mem_ready)  w_next = c_ST_DECODE;
            else if (w_timeout) w_next = c_ST_TRAP;
            else                w_next = c_ST_FETCH;
         end
         c_ST_DECODE: begin
            case (bus.op)
               c_OP_LW, c_OP_SW: w_next = c_ST_MEMADR;
               c_OP_RTYPE:       w_next = w_funct_ok ? c_ST_EXECUTE : c_ST_TRAP;
               c_OP_BEQ:         w_next = c_ST_BRANCH;
               c_OP_ADDI:        w_next = c_ST_ADDIEX;
               c_OP_J:           w_next = c_ST_JUMP;
               default:          w_next = c_ST_TRAP;
            endcase
         end
         c_ST_MEMADR:  w_next = (bus.op == c_OP_SW) ? c_ST_MEMWRITE : c_ST_MEMREAD;
         c_ST_MEMREAD: begin
            if (bus.mem_ready)  w_next = c_ST_MEMWB;
            else if (w_timeout) w_next = c_ST_TRAP;
            else                w_next = c_ST_MEMREAD;
         end
         c_ST_MEMWRITE: begin
            if (bus.mem_ready)  w_next = c_ST_FETCH;
            else if (w_timeout) w_next = c_ST_TRAP;
            else                w_next = c_ST_MEMWRITE;
         end
         c_ST_EXECUTE: w_next = c_ST_ALUWB;
         c_ST_ADDIEX:  w_next = c_ST_ADDIWB;
         default:      w_next = c_ST_FETCH;
      endcase
   end

   always_comb begin
      bus.pc_en         = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.ir_write      = 1'b0;
      bus.ALU_src_a     = 1'b0;
      bus.ALU_src_b     = 2'b00;
      bus.ALU_control   = 3'b000;
      bus.pc_src        = 2'b00;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.mem_write     = 1'b0;
      bus.illegal_instr = 1'b0;
      bus.bus_error     = 1'b0;
      case (r_state)
         c_ST_FETCH: begin
            bus.ALU_src_b   = 2'b01;
            bus.ALU_control = c_ALU_ADD;
            bus.pc_en       = bus.mem_ready;
            bus.ir_write    = bus.mem_ready;
         end
         c_ST_DECODE: begin
            bus.ALU_src_b   = 2'b11;
            bus.ALU_control = c_ALU_ADD;
         end
         c_ST_MEMADR, c_ST_ADDIEX: begin
            bus.ALU_src_a   = 1'b1;
            bus.ALU_src_b   = 2'b10;
            bus.ALU_control = c_ALU_ADD;
         end
         c_ST_MEMREAD: bus.i_or_d = 1'b1;
         c_ST_MEMWB: begin
            bus.mem_to_reg = 1'b1;
            bus.reg_write  = 1'b1;
         end
         c_ST_MEMWRITE: begin
            bus.i_or_d    = 1'b1;
            bus.mem_write = 1'b1;
         end
         c_ST_EXECUTE: begin
            bus.ALU_src_a = 1'b1;
            case (bus.funct)
               c_FN_SUB: bus.ALU_control = c_ALU_SUB;
               c_FN_AND: bus.ALU_control = c_ALU_AND;
               c_FN_OR:  bus.ALU_control = c_ALU_OR;
               c_FN_SLT: bus.ALU_control = c_ALU_SLT;
               default:  bus.ALU_control = c_ALU_ADD;
            endcase
         end
         c_ST_ALUWB: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
         end
         c_ST_BRANCH: begin
            bus.ALU_src_a   = 1'b1;
            bus.ALU_control = c_ALU_SUB;
            bus.pc_src      = 2'b01;
            bus.pc_en       = bus.zero;
         end
         c_ST_ADDIWB: bus.reg_write = 1'b1;
         c_ST_JUMP: begin
            bus.pc_src = 2'b10;
            bus.pc_en  = 1'b1;
         end
         c_ST_TRAP: begin
            bus.illegal_instr = !r_cause_bus;
            bus.bus_error     = r_cause_bus;
         end
         default: ;
      endcase
      // Strobes must drop the instant reset asserts, even while FETCH sees mem_ready high.
      if (!rst_n) begin
         bus.pc_en         = 1'b0;
         bus.ir_write      = 1'b0;
         bus.reg_write     = 1'b0;
         bus.mem_write     = 1'b0;
         bus.illegal_instr = 1'b0;
         bus.bus_error     = 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one parameter: MEM_TIMEOUT, default 255, the maximum number of wait cycles for mem_ready (legal range 1..255).
REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction opcode from the instruction register
- funct  in  6  R-type function field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC register enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out
- ir_write  out  1  instruction register load
- ALU_src_a  out  1  srcA select: 0 = PC, 1 = reg A
- ALU_src_b  out  2  srcB select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- ALU_control  out  3  ALU operation code
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALU out, 10 = jump target
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback select: 1 = memory data
- reg_write  out  1  register file write
- mem_write  out  1  data memory write
- illegal_instr  out  1  one-cycle pulse on an unsupported op or funct
- bus_error  out  1  one-cycle pulse on a mem_ready timeout
- state  out  4  current state code, for debug

Function
REQ-004 The block SHALL have these states and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-005 Every control output not listed for a state SHALL be 0; the outputs SHALL depend only on state, except for the mem_ready and zero gating defined below.
REQ-006 ALU_control encoding SHALL be: add 010, sub 110, and 000, or 001, slt 111.
REQ-007 FETCH SHALL drive i_or_d 0, ALU_src_a 0, ALU_src_b 01, ALU_control add, and pc_src 00.
- ir_write and pc_en SHALL be 1 only in a cycle where mem_ready is 1; that cycle SHALL go to DECODE.
- Otherwise the block SHALL stay in FETCH.
REQ-008 DECODE SHALL drive ALU_src_a 0, ALU_src_b 11, and ALU_control add. The next state SHALL be set by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXECUTE if funct is one of 100000, 100010, 100100, 100101, 101010; otherwise TRAP
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other op -> TRAP
REQ-009 MEMADR SHALL drive ALU_src_a 1, ALU_src_b 10, and ALU_control add, then go to MEMREAD for lw or MEMWRITE for sw.
REQ-010 MEMREAD SHALL drive i_or_d 1; it SHALL go to MEMWB when mem_ready is 1 and otherwise stay.
REQ-011 MEMWB SHALL drive reg_dst 0, mem_to_reg 1, and reg_write 1, then go to FETCH.
REQ-012 MEMWRITE SHALL drive i_or_d 1 and hold mem_write at 1 until the mem_ready cycle (inclusive), then go to FETCH.
REQ-013 EXECUTE SHALL drive ALU_src_a 1 and ALU_src_b 00, with funct mapping to ALU_control as: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. It SHALL then go to ALUWB.
REQ-014 ALUWB SHALL drive reg_dst 1, mem_to_reg 0, and reg_write 1, then go to FETCH.
REQ-015 BRANCH SHALL drive ALU_src_a 1, ALU_src_b 00, ALU_control sub, pc_src 01, and pc_en = zero, then go to FETCH.
REQ-016 ADDIEX SHALL drive ALU_src_a 1, ALU_src_b 10, and ALU_control add, then go to ADDIWB.
REQ-017 ADDIWB SHALL drive reg_dst 0, mem_to_reg 0, and reg_write 1, then go to FETCH.
REQ-018 JUMP SHALL drive pc_src 10 and pc_en 1, then go to FETCH.
REQ-019 TRAP SHALL last exactly one cycle, with all strobes 0, then go to FETCH; illegal_instr or bus_error SHALL be 1 during that cycle according to the cause.
REQ-020 The wait counter (8 bits) SHALL behave as follows:
- It SHALL clear on entry to FETCH, MEMREAD, or MEMWRITE.
- It SHALL increment each cycle those states wait with mem_ready 0.
- When it reaches MEM_TIMEOUT with mem_ready still 0, the next state SHALL be TRAP with cause bus_error.
- mem_ready 1 in the timeout cycle SHALL win: the access completes normally.
REQ-021 A completed instruction SHALL take, counting zero-wait memory: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.

Reset
REQ-022 Asserting rst_n low SHALL immediately (asynchronously) force state to FETCH, clear the wait counter and trap cause, and drive all strobes (pc_en, ir_write, reg_write, mem_write, illegal_instr, bus_error) to 0, including mid-instruction and mid-wait.
REQ-023 After rst_n deasserts, the first rising edge SHALL evaluate FETCH normally; no instruction state SHALL survive the reset.

Verification
REQ-024 Reset, then op=100011 with mem_ready held 1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-025 op=000000, funct=101010 -> ALU_control=111 in EXECUTE; reg_dst=1 and reg_write=1 in ALUWB; 4 cycles total.
REQ-026 op=000100 with zero=0, then a second beq with zero=1 -> pc_en=0 in the first BRANCH and pc_en=1 with pc_src=01 in the second.
REQ-027 op=111111, then op=000000 with funct=000001 -> each gives DECODE->TRAP with one illegal_instr pulse, then FETCH.
REQ-028 MEM_TIMEOUT=3, sw with mem_ready=0 -> mem_write=1 for 4 cycles, then TRAP with bus_error=1, then FETCH.
REQ-029 rst_n pulsed low while in MEMREAD waiting -> state=0 and all strobes 0 before the next clock edge.
